apb_tx_sequencer: RTL and testbench

APB master sequencer that programs and launches the serial TX peripheral without CPU involvement. On a start request it writes the control register, streams N payload words into the TX data register, writes the two configuration registers, then issues the command write. It sits between a payload source (valid/ready stream) and the TX peripheral's APB slave port, in the PCLK domain.

---
 rtl/apb_tx_sequencer_pkg.sv | 35 +++
 rtl/apb_tx_sequencer_apb_master_port.sv | 29 ++
 rtl/apb_tx_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_apb_tx_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_tx_sequencer_pkg.sv
// Shared definitions for the APB TX sequencer: register map, FSM states and transfer phases.
// Optional status polling is enabled by defining SEQ_STATUS_POLL_EN.
package apb_tx_sequencer_pkg;

  localparam int ADDR_CTRL   = 0;
  localparam int ADDR_CMD    = 1;
  localparam int ADDR_TXDATA = 2;
  localparam int ADDR_CFG    = 3;
  localparam int ADDR_DIV    = 4;
  localparam int ADDR_STATUS = 5;

  localparam int STATUS_BUSY_BIT = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_FETCH,
`ifdef SEQ_STATUS_POLL_EN
    ST_POLL_SETUP,
    ST_POLL_ACCESS,
`endif
    ST_DONE
  } state_e;

  typedef enum logic [2:0] {
    PH_CTRL,
    PH_DATA,
    PH_CFG,
    PH_DIV,
    PH_CMD,
    PH_STATUS
  } phase_e;

endpackage

// File: rtl/apb_tx_sequencer_apb_master_port.sv
// APB SETUP/ACCESS signalling for the sequencer; outputs are forced to zero outside a transfer
// so that an asynchronous reset of the owning FSM drops the bus immediately.
module apb_master_port #(
  parameter int ADDRESSWIDTH = 3,
  parameter int DATAWIDTH    = 16
) (
  input  logic                    req_i,
  input  logic                    access_i,
  input  logic [ADDRESSWIDTH-1:0] addr_i,
  input  logic [DATAWIDTH-1:0]    wdata_i,
  input  logic                    write_i,
  input  logic                    PREADY_i,
  output logic [ADDRESSWIDTH-1:0] PADDR_o,
  output logic [DATAWIDTH-1:0]    PWDATA_o,
  output logic                    PWRITE_o,
  output logic                    PSELx_o,
  output logic                    PENABLE_o,
  output logic                    done_o
);

  assign PSELx_o   = req_i;
  assign PENABLE_o = req_i & access_i;
  assign PADDR_o   = req_i ? addr_i : '0;
  assign PWRITE_o  = req_i & write_i;
  // Reads never expose stale write data on the bus.
  assign PWDATA_o  = (req_i && write_i) ? wdata_i : '0;
  assign done_o    = req_i & access_i & PREADY_i;

endmodule

// File: rtl/apb_tx_sequencer.sv
// Autonomous APB master that programs the TX peripheral: CTRL, N payload words, CFG, DIV, CMD.
// Define SEQ_STATUS_POLL_EN to poll STATUS after CMD until the busy bit clears.
module apb_tx_sequencer
  import apb_tx_sequencer_pkg::*;
#(
  parameter int ADDRESSWIDTH = 3,
  parameter int DATAWIDTH    = 16,
  parameter int MAX_WORDS    = 64,
  localparam int CW          = $clog2(MAX_WORDS + 1)
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic [CW-1:0]           count_i,
  input  logic [DATAWIDTH-1:0]    ctrl_i,
  input  logic [DATAWIDTH-1:0]    cfg_i,
  input  logic [DATAWIDTH-1:0]    div_i,
  input  logic [DATAWIDTH-1:0]    cmd_i,
  input  logic [DATAWIDTH-1:0]    data_i,
  input  logic                    data_valid_i,
  output logic                    data_ready_o,
  output logic [ADDRESSWIDTH-1:0] PADDR_o,
  output logic [DATAWIDTH-1:0]    PWDATA_o,
  output logic                    PWRITE_o,
  output logic                    PSELx_o,
  output logic                    PENABLE_o,
  input  logic [DATAWIDTH-1:0]    PRDATA_i,
  input  logic                    PREADY_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    aborted_o
);

  state_e                 state_q, state_d;
  phase_e                 phase_q, phase_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [CW-1:0]          nwords_q;
  logic [DATAWIDTH-1:0]   ctrl_q, cfg_q, div_q, cmd_q, word_q;
  logic                   aborted_q, aborted_d;

  logic                   load_start, load_word;
  logic [CW-1:0]          count_clamped, cnt_inc;
  logic                   req, access, xfer_done;
  logic [ADDRESSWIDTH-1:0] addr;
  logic [DATAWIDTH-1:0]   wdata;
  logic                   write;

  assign count_clamped = (count_i > CW'(MAX_WORDS)) ? CW'(MAX_WORDS) : count_i;
  assign cnt_inc       = cnt_q + CW'(1);

  assign load_start = (state_q == ST_IDLE) && start_i;
  assign load_word  = (state_q == ST_FETCH) && !abort_i && data_valid_i;

  // Bus contents depend only on the registered phase, so they hold through wait states.
  always_comb begin
    addr  = '0;
    wdata = '0;
    write = 1'b1;
    case (phase_q)
      PH_CTRL:   begin addr = ADDRESSWIDTH'(ADDR_CTRL);   wdata = ctrl_q; end
      PH_DATA:   begin addr = ADDRESSWIDTH'(ADDR_TXDATA); wdata = word_q; end
      PH_CFG:    begin addr = ADDRESSWIDTH'(ADDR_CFG);    wdata = cfg_q;  end
      PH_DIV:    begin addr = ADDRESSWIDTH'(ADDR_DIV);    wdata = div_q;  end
      PH_CMD:    begin addr = ADDRESSWIDTH'(ADDR_CMD);    wdata = cmd_q;  end
      PH_STATUS: begin addr = ADDRESSWIDTH'(ADDR_STATUS); write = 1'b0;   end
      default:   write = 1'b0;
    endcase
  end

  always_comb begin
    req    = 1'b0;
    access = 1'b0;
    case (state_q)
      ST_SETUP:       req = 1'b1;
      ST_ACCESS:      begin req = 1'b1; access = 1'b1; end
`ifdef SEQ_STATUS_POLL_EN
      ST_POLL_SETUP:  req = 1'b1;
      ST_POLL_ACCESS: begin req = 1'b1; access = 1'b1; end
`endif
      default: ;
    endcase
  end

  apb_master_port #(
    .ADDRESSWIDTH(ADDRESSWIDTH),
    .DATAWIDTH   (DATAWIDTH)
  ) u_port (
    .req_i    (req),
    .access_i (access),
    .addr_i   (addr),
    .wdata_i  (wdata),
    .write_i  (write),
    .PREADY_i (PREADY_i),
    .PADDR_o  (PADDR_o),
    .PWDATA_o (PWDATA_o),
    .PWRITE_o (PWRITE_o),
    .PSELx_o  (PSELx_o),
    .PENABLE_o(PENABLE_o),
    .done_o   (xfer_done)
  );

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    aborted_d = aborted_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d   = ST_SETUP;
          phase_d   = PH_CTRL;
          cnt_d     = '0;
          aborted_d = 1'b0;
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (xfer_done) begin
          if (abort_i) begin
            state_d   = ST_DONE;
            aborted_d = 1'b1;
          end else begin
            case (phase_q)
              PH_CTRL: begin
                if (nwords_q == '0) begin
                  phase_d = PH_CFG;
                  state_d = ST_SETUP;
                end else begin
                  phase_d = PH_DATA;
                  state_d = ST_FETCH;
                end
              end
              PH_DATA: begin
                cnt_d = cnt_inc;
                if (cnt_inc == nwords_q) begin
                  phase_d = PH_CFG;
                  state_d = ST_SETUP;
                end else begin
                  state_d = ST_FETCH;
                end
              end
              PH_CFG: begin phase_d = PH_DIV; state_d = ST_SETUP; end
              PH_DIV: begin phase_d = PH_CMD; state_d = ST_SETUP; end
`ifdef SEQ_STATUS_POLL_EN
              PH_CMD: begin phase_d = PH_STATUS; state_d = ST_POLL_SETUP; end
`else
              PH_CMD: state_d = ST_DONE;
`endif
              default: state_d = ST_DONE;
            endcase
          end
        end
      end
      ST_FETCH: begin
        if (abort_i) begin
          state_d   = ST_DONE;
          aborted_d = 1'b1;
        end else if (data_valid_i) begin
          state_d = ST_SETUP;
        end
      end
`ifdef SEQ_STATUS_POLL_EN
      ST_POLL_SETUP: state_d = ST_POLL_ACCESS;
      ST_POLL_ACCESS: begin
        if (xfer_done) begin
          if (abort_i) begin
            state_d   = ST_DONE;
            aborted_d = 1'b1;
          end else if (PRDATA_i[STATUS_BUSY_BIT]) begin
            state_d = ST_POLL_SETUP;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= ST_IDLE;
      phase_q   <= PH_CTRL;
      cnt_q     <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      aborted_q <= aborted_d;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      nwords_q <= '0;
      ctrl_q   <= '0;
      cfg_q    <= '0;
      div_q    <= '0;
      cmd_q    <= '0;
      word_q   <= '0;
    end else begin
      if (load_start) begin
        nwords_q <= count_clamped;
        ctrl_q   <= ctrl_i;
        cfg_q    <= cfg_i;
        div_q    <= div_i;
        cmd_q    <= cmd_i;
      end
      if (load_word) word_q <= data_i;
    end
  end

  assign data_ready_o = (state_q == ST_FETCH) && !abort_i;
  assign busy_o       = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done_o       = (state_q == ST_DONE);
  assign aborted_o    = (state_q == ST_DONE) && aborted_q;

  // Only the busy bit of STATUS matters; the rest of the read data is intentionally ignored.
  logic unused_prdata;
  assign unused_prdata = ^PRDATA_i;

endmodule

// File: tb/tb_apb_tx_sequencer.sv
// Scoreboard bench for apb_tx_sequencer: expected APB transfers are queued per test and checked
// by a monitor on every selected bus cycle; completion timing is checked by the stimulus thread.
module tb_apb_tx_sequencer;
  localparam int AW = 3;
  localparam int DW = 16;
  localparam int MW = 64;
  localparam int CW = 7;
`ifdef SEQ_STATUS_POLL_EN
  localparam int POLL = 1;
`else
  localparam int POLL = 0;
`endif

  logic          PCLK, PRESET;
  logic          start_i, abort_i, data_valid_i, data_ready_o;
  logic [CW-1:0] count_i;
  logic [DW-1:0] ctrl_i, cfg_i, div_i, cmd_i, data_i, PWDATA_o, PRDATA_i;
  logic [AW-1:0] PADDR_o;
  logic          PWRITE_o, PSELx_o, PENABLE_o, PREADY_i, busy_o, done_o, aborted_o;

  apb_tx_sequencer #(.ADDRESSWIDTH(AW), .DATAWIDTH(DW), .MAX_WORDS(MW)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .start_i(start_i), .abort_i(abort_i), .count_i(count_i),
    .ctrl_i(ctrl_i), .cfg_i(cfg_i), .div_i(div_i), .cmd_i(cmd_i), .data_i(data_i),
    .data_valid_i(data_valid_i), .data_ready_o(data_ready_o), .PADDR_o(PADDR_o),
    .PWDATA_o(PWDATA_o), .PWRITE_o(PWRITE_o), .PSELx_o(PSELx_o), .PENABLE_o(PENABLE_o),
    .PRDATA_i(PRDATA_i), .PREADY_i(PREADY_i), .busy_o(busy_o), .done_o(done_o),
    .aborted_o(aborted_o)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          w;
  } xfer_t;

  xfer_t         exp_q[$];
  int            errors = 0;
  int            checks = 0;
  logic [DW-1:0] payload[8];
  int            idx = 0;
  int            gap_at = -1, gap_left = 0;
  int            wait_addr = -1, wait_left = 0;
  bit            abort_arm = 0;
  logic [DW-1:0] poll_vals[4];
  int            poll_n = 0, poll_idx = 0;

  function automatic logic [DW-1:0] word_of(input int i);
    if (i < 8) return payload[i];
    return DW'(i);
  endfunction

  // Monitor: every selected bus cycle must match the head of the expected queue.
  always @(negedge PCLK) begin
    if (!PRESET) begin
      if (data_ready_o) begin
        checks++;
        if (PSELx_o) begin
          errors++;
          $display("FAIL fetch_psel: PSELx_o=%0b during fetch, required 0", PSELx_o);
        end
        if (data_valid_i) idx++;
      end
      if (PSELx_o) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL apb_unexpected: addr=%0d data=%h write=%0b, required no transfer",
                   PADDR_o, PWDATA_o, PWRITE_o);
        end else begin
          if (PADDR_o !== exp_q[0].a || PWDATA_o !== exp_q[0].d || PWRITE_o !== exp_q[0].w) begin
            errors++;
            $display("FAIL apb_xfer: got addr=%0d data=%h write=%0b, required addr=%0d data=%h write=%0b",
                     PADDR_o, PWDATA_o, PWRITE_o, exp_q[0].a, exp_q[0].d, exp_q[0].w);
          end
          if (PENABLE_o && PREADY_i) begin
            if (PADDR_o == 3'd5 && !PWRITE_o) poll_idx++;
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  // Environment driver: payload, valid gaps, wait states, abort and status read data.
  initial forever begin
    @(posedge PCLK);
    #1;
    data_i = word_of(idx);
    if (data_ready_o && idx == gap_at && gap_left > 0) begin
      data_valid_i = 1'b0;
      gap_left--;
    end else data_valid_i = 1'b1;
    if (PSELx_o && PENABLE_o && int'(PADDR_o) == wait_addr && wait_left > 0) begin
      PREADY_i = 1'b0;
      wait_left--;
    end else PREADY_i = 1'b1;
    abort_i  = abort_arm && PSELx_o && PENABLE_o && PADDR_o == 3'd2 && idx == 2;
    PRDATA_i = (poll_idx < poll_n) ? poll_vals[poll_idx[1:0]] : '0;
  end

  task automatic push(input int a, input logic [DW-1:0] d, input logic w);
    xfer_t x;
    x.a = AW'(a);
    x.d = d;
    x.w = w;
    exp_q.push_back(x);
  endtask

  task automatic push_full(input int n, input logic [DW-1:0] c, cf, dv, cm, input int npoll);
    push(0, c, 1'b1);
    for (int i = 0; i < n; i++) push(2, word_of(i), 1'b1);
    push(3, cf, 1'b1);
    push(4, dv, 1'b1);
    push(1, cm, 1'b1);
    for (int i = 0; i < npoll; i++) push(5, '0, 1'b0);
  endtask

  task automatic start_seq(input int n, input logic [DW-1:0] c, cf, dv, cm);
    count_i  = CW'(n);
    ctrl_i   = c;
    cfg_i    = cf;
    div_i    = dv;
    cmd_i    = cm;
    idx      = 0;
    poll_idx = 0;
    data_i   = word_of(0);
    start_i  = 1'b1;
    @(posedge PCLK);
    #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_cycle, input logic exp_ab);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    while (n < 400 && !seen) begin
      @(posedge PCLK);
      #1;
      n++;
      if (done_o) seen = 1;
    end
    checks++;
    if (!seen || n + 1 != exp_cycle) begin
      errors++;
      $display("FAIL %s_cycle: done at cycle %0d (seen=%0b), required %0d", name, n + 1, seen, exp_cycle);
    end
    checks++;
    if (aborted_o !== exp_ab || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_flags: aborted=%0b busy=%0b, required aborted=%0b busy=0",
               name, aborted_o, busy_o, exp_ab);
    end
    @(posedge PCLK);
    #1;
    checks++;
    if (done_o !== 1'b0 || aborted_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_pulse: done=%0b aborted=%0b one cycle later, required 0 0", name, done_o, aborted_o);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing: %0d transfers never seen, required 0", name, exp_q.size());
    end
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if ({PADDR_o, PWDATA_o, PWRITE_o, PSELx_o, PENABLE_o, data_ready_o, busy_o, done_o, aborted_o} !== '0) begin
      errors++;
      $display("FAIL %s: addr=%0d wdata=%h pwrite=%0b psel=%0b pen=%0b rdy=%0b busy=%0b done=%0b ab=%0b, required all 0",
               name, PADDR_o, PWDATA_o, PWRITE_o, PSELx_o, PENABLE_o, data_ready_o, busy_o, done_o, aborted_o);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    PRESET = 1'b1; start_i = 1'b0; abort_i = 1'b0; count_i = '0;
    ctrl_i = '0; cfg_i = '0; div_i = '0; cmd_i = '0; data_i = '0;
    data_valid_i = 1'b1; PREADY_i = 1'b1; PRDATA_i = '0;
    for (int i = 0; i < 8; i++) payload[i] = DW'(i + 1);
    poll_vals[0] = 16'h1; poll_vals[1] = 16'h1; poll_vals[2] = 16'h0; poll_vals[3] = 16'h0;
    repeat (3) @(posedge PCLK);
    #1;
    check_idle_outputs("reset_state");
    PRESET = 1'b0;
    @(posedge PCLK);
    #1;

    push_full(0, 16'h0060, 16'h0008, 16'h0001, 16'h0058, POLL);
    start_seq(0, 16'h0060, 16'h0008, 16'h0001, 16'h0058);
    wait_done("n0", 9 + 2 * POLL, 1'b0);

    push_full(3, 16'hA001, 16'h00C3, 16'h0010, 16'h0005, POLL);
    start_seq(3, 16'hA001, 16'h00C3, 16'h0010, 16'h0005);
    wait_done("n3", 18 + 2 * POLL, 1'b0);

    gap_at = 1; gap_left = 4;
    push_full(3, 16'h1111, 16'h2222, 16'h3333, 16'h4444, POLL);
    start_seq(3, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
    wait_done("valid_gap", 22 + 2 * POLL, 1'b0);
    gap_at = -1;

    wait_addr = 3; wait_left = 3;
    push_full(0, 16'h00F0, 16'hBEEF, 16'h0042, 16'h0007, POLL);
    start_seq(0, 16'h00F0, 16'hBEEF, 16'h0042, 16'h0007);
    wait_done("pready_wait", 12 + 2 * POLL, 1'b0);
    wait_addr = -1;

    abort_arm = 1;
    push(0, 16'h0ABC, 1'b1);
    push(2, 16'h0001, 1'b1);
    push(2, 16'h0002, 1'b1);
    start_seq(5, 16'h0ABC, 16'h0DEF, 16'h0123, 16'h0456);
    wait_done("abort", 9, 1'b1);
    abort_arm = 0;

    push_full(64, 16'h5A5A, 16'h0001, 16'h0002, 16'h0003, POLL);
    start_seq(100, 16'h5A5A, 16'h0001, 16'h0002, 16'h0003);
    wait_done("clamp", 9 + 3 * 64 + 2 * POLL, 1'b0);

    push_full(2, 16'h7777, 16'h0001, 16'h0002, 16'h0003, POLL);
    start_seq(2, 16'h7777, 16'h0001, 16'h0002, 16'h0003);
    hit = 0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(posedge PCLK);
      #1;
      if (PSELx_o && PENABLE_o && PADDR_o == 3'd2) hit = 1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL reset_reach_access: hit=%0b, required 1", hit);
    end
    #2;
    PRESET = 1'b1;
    #1;
    check_idle_outputs("reset_mid_access");
    exp_q.delete();
    repeat (2) @(posedge PCLK);
    #1;
    PRESET = 1'b0;
    @(posedge PCLK);
    #1;
    push_full(1, 16'h0060, 16'h0008, 16'h0001, 16'h0058, POLL);
    start_seq(1, 16'h0060, 16'h0008, 16'h0001, 16'h0058);
    wait_done("after_reset", 12 + 2 * POLL, 1'b0);

`ifdef SEQ_STATUS_POLL_EN
    poll_n = 3;
    push_full(0, 16'h0060, 16'h0008, 16'h0001, 16'h0058, 3);
    start_seq(0, 16'h0060, 16'h0008, 16'h0001, 16'h0058);
    wait_done("poll", 15, 1'b0);
    poll_n = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
